// File: rtl/apb_master_if_if.sv
// Local-request and APB bus signal bundle for apb_master_if.
// The master modport is the bridge's view; slave is the view of whoever drives it.
interface apb_master_if_if #(
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned APB_ADDR_WIDTH = 32
);
    localparam int unsigned StrbW = APB_DATA_WIDTH / 8;

    // Local initiator side
    logic                      other_req_in;
    logic                      other_ready_out;
    logic [APB_ADDR_WIDTH-1:0] other_addr_in;
    logic                      other_write_in;
    logic [APB_DATA_WIDTH-1:0] other_wdata_in;
    logic [StrbW-1:0]          other_strb_in;
    logic [2:0]                other_prot_in;
    logic                      other_done_out;
    logic [APB_DATA_WIDTH-1:0] other_rdata_out;
    logic                      other_error_out;

    // APB side
    logic [APB_ADDR_WIDTH-1:0] apb_addr_out;
    logic                      apb_psel_out;
    logic                      apb_penable_out;
    logic                      apb_write_out;
    logic [APB_DATA_WIDTH-1:0] apb_wdata_out;
    logic [StrbW-1:0]          apb_strb_out;
    logic [2:0]                apb_prot_out;
    logic [APB_DATA_WIDTH-1:0] apb_rdata_in;
    logic                      apb_ready_in;
    logic                      apb_slverr_in;

    modport master (
        input  other_req_in, other_addr_in, other_write_in, other_wdata_in, other_strb_in,
        input  other_prot_in,
        output other_ready_out, other_done_out, other_rdata_out, other_error_out,
        output apb_addr_out, apb_psel_out, apb_penable_out, apb_write_out, apb_wdata_out,
        output apb_strb_out, apb_prot_out,
        input  apb_rdata_in, apb_ready_in, apb_slverr_in
    );

    modport slave (
        output other_req_in, other_addr_in, other_write_in, other_wdata_in, other_strb_in,
        output other_prot_in,
        input  other_ready_out, other_done_out, other_rdata_out, other_error_out,
        input  apb_addr_out, apb_psel_out, apb_penable_out, apb_write_out, apb_wdata_out,
        input  apb_strb_out, apb_prot_out,
        output apb_rdata_in, apb_ready_in, apb_slverr_in
    );
endinterface

// File: rtl/apb_master_if.sv
// APB requester bridge: turns single local valid/ready requests into APB SETUP/ACCESS
// transfers, with an ACCESS-phase timeout that reports an error to the initiator.
module apb_master_if #(
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            apb_clk_in,
    input  logic            apb_rstn_in,
    apb_master_if_if.master bus
);
    localparam int unsigned StrbW = APB_DATA_WIDTH / 8;
    localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e state_q, state_d;

    logic [APB_ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                      write_q, write_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [StrbW-1:0]          strb_q,  strb_d;
    logic [2:0]                prot_q,  prot_d;
    logic                      psel_q,  psel_d;
    logic                      pen_q,   pen_d;
    logic                      done_q,  done_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      error_q, error_d;
    logic [CntW-1:0]           cnt_q,   cnt_d;

    // State register
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.other_req_in) begin
                    state_d = StSetup;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (bus.apb_ready_in || (cnt_q == CntMax)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        prot_d  = prot_q;
        psel_d  = psel_q;
        pen_d   = pen_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        error_d = error_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.other_req_in) begin
                    addr_d  = bus.other_addr_in;
                    write_d = bus.other_write_in;
                    // Reads never present stale write data or strobes on the bus
                    wdata_d = bus.other_write_in ? bus.other_wdata_in : '0;
                    strb_d  = bus.other_write_in ? bus.other_strb_in : '0;
                    prot_d  = bus.other_prot_in;
                    psel_d  = 1'b1;
                    pen_d   = 1'b0;
                end
            end
            StSetup: begin
                pen_d = 1'b1;
                cnt_d = '0;
            end
            StAccess: begin
                if (bus.apb_ready_in) begin
                    psel_d  = 1'b0;
                    pen_d   = 1'b0;
                    done_d  = 1'b1;
                    error_d = bus.apb_slverr_in;
                    rdata_d = write_q ? '0 : bus.apb_rdata_in;
                end else if (cnt_q == CntMax) begin
                    psel_d  = 1'b0;
                    pen_d   = 1'b0;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                psel_d = 1'b0;
                pen_d  = 1'b0;
            end
        endcase
    end

    // Reset clears psel/penable asynchronously, so a reset mid-transfer drops the bus at once
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            psel_q  <= 1'b0;
            pen_q   <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            prot_q  <= prot_d;
            psel_q  <= psel_d;
            pen_q   <= pen_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.other_ready_out = (state_q == StIdle);
    assign bus.other_done_out  = done_q;
    assign bus.other_rdata_out = rdata_q;
    assign bus.other_error_out = error_q;
    assign bus.apb_addr_out    = addr_q;
    assign bus.apb_psel_out    = psel_q;
    assign bus.apb_penable_out = pen_q;
    assign bus.apb_write_out   = write_q;
    assign bus.apb_wdata_out   = wdata_q;
    assign bus.apb_strb_out    = strb_q;
    assign bus.apb_prot_out    = prot_q;

endmodule

// File: tb/tb_apb_master_if.sv
// Directed bench for apb_master_if with TIMEOUT_CYCLES=4 and hand-computed expectations.
module tb_apb_master_if;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    apb_master_if_if #(.APB_DATA_WIDTH(DW), .APB_ADDR_WIDTH(AW)) bus ();

    apb_master_if #(
        .APB_DATA_WIDTH(DW),
        .APB_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .apb_clk_in (clk),
        .apb_rstn_in(rstn),
        .bus        (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, " psel"},    64'(bus.apb_psel_out),    64'(0));
        chk({tag, " penable"}, 64'(bus.apb_penable_out), 64'(0));
        chk({tag, " done"},    64'(bus.other_done_out),  64'(0));
        chk({tag, " ready"},   64'(bus.other_ready_out), 64'(1));
    endtask

    // One complete transfer starting from IDLE; waits >= TO means the slave never answers
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                        input int waits, input logic slverr, input logic [31:0] prdata,
                        input int exp_acc, input logic exp_err, input logic [31:0] exp_rdata);
        int acc = 0;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_strb;
        exp_wdata = wr ? wdata : 32'h0;
        exp_strb  = wr ? strb : 4'h0;
        bus.other_req_in   = 1'b1;
        bus.other_write_in = wr;
        bus.other_addr_in  = addr;
        bus.other_wdata_in = wdata;
        bus.other_strb_in  = strb;
        bus.other_prot_in  = prot;
        chk({tag, " ready before"}, 64'(bus.other_ready_out), 64'(1));
        tick;
        // Scramble local inputs: they must be ignored outside IDLE
        bus.other_req_in   = 1'b0;
        bus.other_addr_in  = ~addr;
        bus.other_wdata_in = ~wdata;
        bus.other_write_in = ~wr;
        chk({tag, " setup psel"},    64'(bus.apb_psel_out),    64'(1));
        chk({tag, " setup penable"}, 64'(bus.apb_penable_out), 64'(0));
        chk({tag, " setup ready"},   64'(bus.other_ready_out), 64'(0));
        chk({tag, " paddr"},         64'(bus.apb_addr_out),    64'(addr));
        chk({tag, " pwrite"},        64'(bus.apb_write_out),   64'(wr));
        chk({tag, " pwdata"},        64'(bus.apb_wdata_out),   64'(exp_wdata));
        chk({tag, " pstrb"},         64'(bus.apb_strb_out),    64'(exp_strb));
        chk({tag, " pprot"},         64'(bus.apb_prot_out),    64'(prot));
        tick;
        while (acc < int'(TO) + 1 && !bus.other_done_out) begin
            chk({tag, " access penable"}, 64'(bus.apb_penable_out), 64'(1));
            chk({tag, " access psel"},    64'(bus.apb_psel_out),    64'(1));
            chk({tag, " access paddr"},   64'(bus.apb_addr_out),    64'(addr));
            chk({tag, " access pwdata"},  64'(bus.apb_wdata_out),   64'(exp_wdata));
            bus.apb_ready_in  = (acc == waits);
            bus.apb_slverr_in = (acc == waits) ? slverr : 1'b1;
            bus.apb_rdata_in  = (acc == waits) ? prdata : (32'hBAD0_0000 | 32'(acc));
            acc++;
            tick;
        end
        bus.apb_ready_in  = 1'b0;
        bus.apb_slverr_in = 1'b0;
        bus.apb_rdata_in  = 32'h0;
        chk({tag, " access cycles"}, 64'(acc),                 64'(exp_acc));
        chk({tag, " done"},          64'(bus.other_done_out),  64'(1));
        chk({tag, " error"},         64'(bus.other_error_out), 64'(exp_err));
        chk({tag, " rdata"},         64'(bus.other_rdata_out), 64'(exp_rdata));
        chk({tag, " end psel"},      64'(bus.apb_psel_out),    64'(0));
        chk({tag, " end penable"},   64'(bus.apb_penable_out), 64'(0));
        chk({tag, " end ready"},     64'(bus.other_ready_out), 64'(1));
        tick;
        chk({tag, " done pulse"},  64'(bus.other_done_out),  64'(0));
        chk({tag, " rdata hold"},  64'(bus.other_rdata_out), 64'(exp_rdata));
        chk({tag, " error hold"},  64'(bus.other_error_out), 64'(exp_err));
        chk({tag, " paddr hold"},  64'(bus.apb_addr_out),    64'(addr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [8:0] psel_seq;
        logic [8:0] done_seq;
        bus.other_req_in   = 1'b0;
        bus.other_addr_in  = '0;
        bus.other_write_in = 1'b0;
        bus.other_wdata_in = '0;
        bus.other_strb_in  = '0;
        bus.other_prot_in  = '0;
        bus.apb_rdata_in   = '0;
        bus.apb_ready_in   = 1'b0;
        bus.apb_slverr_in  = 1'b0;

        // Reset values
        tick;
        tick;
        chk_idle_bus("reset");
        chk("reset paddr",  64'(bus.apb_addr_out),    64'(0));
        chk("reset pwrite", 64'(bus.apb_write_out),   64'(0));
        chk("reset pwdata", 64'(bus.apb_wdata_out),   64'(0));
        chk("reset pstrb",  64'(bus.apb_strb_out),    64'(0));
        chk("reset pprot",  64'(bus.apb_prot_out),    64'(0));
        chk("reset rdata",  64'(bus.other_rdata_out), 64'(0));
        chk("reset error",  64'(bus.other_error_out), 64'(0));
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk_idle_bus("post-reset");
            chk("post-reset paddr", 64'(bus.apb_addr_out), 64'(0));
        end

        // Zero-wait write: slave drives junk rdata which must not leak through
        xfer("wr0", 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 1'b0, 32'h5555_5555,
             1, 1'b0, 32'h0);
        // Read with 3 wait states
        xfer("rd3", 1'b0, 32'h100, 32'hFFFF_FFFF, 4'hF, 3'b000, 3, 1'b0, 32'h1234_5678,
             4, 1'b0, 32'h1234_5678);
        // Slave error, then a clean read
        xfer("slverr", 1'b0, 32'h200, 32'h0, 4'h0, 3'b001, 0, 1'b1, 32'hAAAA_5555,
             1, 1'b1, 32'hAAAA_5555);
        xfer("clean", 1'b0, 32'h204, 32'h0, 4'h0, 3'b001, 1, 1'b0, 32'h0000_1234,
             2, 1'b0, 32'h0000_1234);
        // Timeout: slave never ready
        xfer("timeout", 1'b0, 32'h300, 32'h0, 4'h0, 3'b000, 99, 1'b0, 32'h0,
             4, 1'b1, 32'h0);
        // Ready on the final allowed cycle is a success
        xfer("lastcyc", 1'b0, 32'h304, 32'h0, 4'h0, 3'b100, 3, 1'b0, 32'hCAFE_F00D,
             4, 1'b0, 32'hCAFE_F00D);
        // Write with slave error
        xfer("wrerr", 1'b1, 32'h308, 32'h0BAD_CAFE, 4'h3, 3'b111, 2, 1'b1, 32'h7777_7777,
             3, 1'b1, 32'h0);

        // Back-to-back: req held high with a zero-wait slave
        bus.other_req_in   = 1'b1;
        bus.other_write_in = 1'b1;
        bus.other_addr_in  = 32'h500;
        bus.other_wdata_in = 32'h1;
        bus.other_strb_in  = 4'hF;
        bus.apb_ready_in   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick;
            psel_seq[8-i] = bus.apb_psel_out;
            done_seq[8-i] = bus.other_done_out;
        end
        bus.other_req_in = 1'b0;
        bus.apb_ready_in = 1'b0;
        chk("b2b psel pattern", 64'(psel_seq), 64'(9'b110110110));
        chk("b2b done pattern", 64'(done_seq), 64'(9'b001001001));
        tick;
        chk_idle_bus("b2b after");

        // Reset during ACCESS
        bus.other_req_in   = 1'b1;
        bus.other_write_in = 1'b0;
        bus.other_addr_in  = 32'h600;
        tick;
        bus.other_req_in = 1'b0;
        tick;
        tick;
        chk("midrst access penable", 64'(bus.apb_penable_out), 64'(1));
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst psel",    64'(bus.apb_psel_out),    64'(0));
        chk("midrst penable", 64'(bus.apb_penable_out), 64'(0));
        chk("midrst ready",   64'(bus.other_ready_out), 64'(1));
        chk("midrst done",    64'(bus.other_done_out),  64'(0));
        tick;
        tick;
        chk("midrst held done", 64'(bus.other_done_out), 64'(0));
        chk("midrst paddr",     64'(bus.apb_addr_out),   64'(0));
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_idle_bus("midrst release");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/apb_master_if.md
# apb_master_if

APB requester-side bridge: accepts single read/write requests from a local module over a simple valid/ready handshake and drives them onto an APB bus as SETUP/ACCESS transfers. It returns read data and error status to the local module. It is the counterpart of the APB slave interface and sits between an on-chip initiator and the APB fabric.

## Interface

Parameters:
- APB_DATA_WIDTH, 32, data bus width; multiple of 8
- APB_ADDR_WIDTH, 32, address bus width
- TIMEOUT_CYCLES, 16, max ACCESS cycles before abort; ≥1. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- apb_clk_in  in  1  clock; all logic on posedge
- apb_rstn_in  in  1  asynchronous active-low reset
- other_req_in  in  1  local request valid
- other_ready_out  out  1  local request accepted when high with other_req_in
- other_addr_in  in  APB_ADDR_WIDTH  request address
- other_write_in  in  1  1=write, 0=read
- other_wdata_in  in  APB_DATA_WIDTH  write data
- other_strb_in  in  APB_DATA_WIDTH/8  write strobes
- other_prot_in  in  3  protection attributes
- other_done_out  out  1  one-cycle completion pulse
- other_rdata_out  out  APB_DATA_WIDTH  read data, valid with done
- other_error_out  out  1  slave error or timeout, valid with done
- apb_addr_out  out  APB_ADDR_WIDTH  PADDR
- apb_psel_out  out  1  PSEL
- apb_penable_out  out  1  PENABLE
- apb_write_out  out  1  PWRITE
- apb_wdata_out  out  APB_DATA_WIDTH  PWDATA
- apb_strb_out  out  APB_DATA_WIDTH/8  PSTRB
- apb_prot_out  out  3  PPROT
- apb_rdata_in  in  APB_DATA_WIDTH  PRDATA
- apb_ready_in  in  1  PREADY
- apb_slverr_in  in  1  PSLVERR

## Operation

- FSM states: IDLE, SETUP, ACCESS. Reset state is IDLE.
- other_ready_out = (state == IDLE). It is combinational and therefore 1 during and after reset.
- IDLE: when other_req_in=1, latch addr/write/wdata/strb/prot onto the apb_*_out registers, set psel=1 and penable=0, then go to SETUP.
  - For reads, apb_wdata_out and apb_strb_out are driven 0.
- SETUP: set penable=1, clear the timeout counter, go to ACCESS. Unconditional.
- ACCESS, apb_ready_in=1: complete the transfer.
  - psel=0, penable=0, other_done_out=1.
  - other_error_out=apb_slverr_in.
  - other_rdata_out = read ? apb_rdata_in : 0.
  - Go to IDLE.
- ACCESS, apb_ready_in=0 and counter == TIMEOUT_CYCLES-1: abort.
  - psel=0, penable=0, other_done_out=1, other_error_out=1, other_rdata_out=0.
  - Go to IDLE.
- ACCESS, otherwise: increment the counter, stay in ACCESS.
- apb_slverr_in and apb_rdata_in are sampled only in ACCESS when apb_ready_in=1.
- Local inputs are ignored outside IDLE.
- apb_addr/write/wdata/strb/prot_out stay stable from SETUP through the end of ACCESS. They hold their last value in IDLE.
- other_rdata_out and other_error_out hold until the next completion. other_done_out is 0 except on the completion cycle.
- Reset values (all outputs 0 except other_ready_out):
  - apb_addr_out, apb_psel_out, apb_penable_out, apb_write_out, apb_wdata_out, apb_strb_out, apb_prot_out: 0.
  - other_done_out, other_rdata_out, other_error_out: 0.
  - Counter: 0.
  - other_ready_out: 1.
- Reset mid-transfer: psel and penable drop asynchronously, the FSM returns to IDLE, and no done pulse is generated.

## Timing

- Edge E0 samples req&&ready. After E0: psel=1, penable=0 (SETUP).
- After E1: penable=1 (ACCESS).
- Zero-wait slave: pready=1 at E2. After E2: done=1 for one cycle, psel=0, ready=1.
- Minimum latency: acceptance to done visible is 2 edges; psel is high for exactly 2 cycles.
- N wait states add N cycles, with N ≤ TIMEOUT_CYCLES-1.
- Timeout: ACCESS lasts exactly TIMEOUT_CYCLES cycles; done/error appear after edge E1+TIMEOUT_CYCLES.
- Back-to-back: next acceptance no earlier than E3. Peak rate is one transfer per 3 cycles; psel deasserts for at least one cycle between transfers.
- pready high on the final timeout cycle counts as success, not timeout.

## Test plan

- Reset: during reset, all APB outputs 0, other_done_out=0, other_ready_out=1. Release reset with req=0: outputs unchanged for 10 cycles.
- Zero-wait write:
  - Stimulus: addr=0x40, wdata=0xDEADBEEF, strb=0xF, prot=3'b010.
  - Required response: SETUP then ACCESS with stable bus values. pready=1 in first ACCESS gives done one cycle after, error=0, rdata=0.
- Read with 3 wait states:
  - Stimulus: addr=0x100, slave returns 0x12345678 on the 4th ACCESS cycle.
  - Required response: penable high 4 cycles, other_rdata_out=0x12345678, done single pulse.
- Slave error: read with pready=1, pslverr=1, prdata=0xAAAA5555 -> error=1, rdata=0xAAAA5555. A following request with pslverr=0 gives error=0.
- Timeout, TIMEOUT_CYCLES=4:
  - pready held 0: penable high exactly 4 cycles, then done=1, error=1, rdata=0, psel=0.
  - Repeat with pready=1 on the 4th cycle: completes successfully.
- Back-to-back and reset mid-op:
  - req held high for 3 requests: accepted at E0, E3, E6, with psel low one cycle between.
  - Assert reset during ACCESS: psel/penable 0 immediately, no done pulse, ready=1 after release.
